square_accumulator: RTL and testbench

Iterative integer squarer. It computes sq = x*x by accumulating successive odd numbers (1+3+5+...), one addition per cycle. Control uses a level-held start/done handshake: st is held high until done is seen, then released. It is the forward (squaring) counterpart to the lab's odd-subtraction square-root datapath, and shares its handshake and timing style.

---
 rtl/square_accumulator_if.sv | 18 +
 rtl/square_accumulator.sv | 69 ++++++
 tb/tb_square_accumulator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/square_accumulator_if.sv
// Start/done handshake bundle for the iterative squarer.
//   st   : start request, level-held by the requester until done is seen
//   x    : operand, sampled on the load cycle only
//   done : result valid (DONE state while st is high)
//   busy : accumulation in progress
//   sq   : accumulator / final square
interface square_accumulator_if #(
  parameter int unsigned W = 4
);
  logic             st;
  logic [W-1:0]     x;
  logic             done;
  logic             busy;
  logic [2*W-1:0]   sq;

  modport master (output st, output x, input done, input busy, input sq);
  modport slave  (input st, input x, output done, output busy, output sq);
endinterface

// File: rtl/square_accumulator.sv
// Iterative squarer: sq = x*x built by summing the first x odd numbers,
// one addition per clock.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : square_accumulator_if slave (st, x in; done, busy, sq out)
module square_accumulator #(
  parameter int unsigned W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  square_accumulator_if.slave  bus
);

  localparam int unsigned SW = 2 * W;  // result width
  localparam int unsigned OW = W + 1;  // largest odd addend 2x-1 needs W+1 bits

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    ADD  = 3'b010,
    DONE = 3'b100
  } state_t;

  state_t         state;
  logic [SW-1:0]  acc;
  logic [OW-1:0]  odd;
  logic [W-1:0]   cnt;

  // Control and datapath; illegal one-hot codes fall back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      odd   <= OW'(1);
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.st) begin
            cnt   <= bus.x;
            acc   <= '0;
            odd   <= OW'(1);
            state <= ADD;
          end
        end
        ADD: begin
          if (cnt != '0) begin
            acc <= acc + SW'(odd);
            odd <= odd + OW'(2);
            cnt <= cnt - W'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          // Stay here while st is held so a held request cannot restart.
          if (!bus.st) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decodes are combinational on state (and st for done).
  assign bus.done = (state == DONE) && bus.st;
  assign bus.busy = (state == ADD);
  assign bus.sq   = acc;

endmodule

// File: tb/tb_square_accumulator.sv
// Self-checking bench for square_accumulator (W=4): directed scenarios plus
// randomized handshakes, checked against arithmetic expectations (k*k after
// k additions, x*x at completion, done after x+1 edges).
module tb_square_accumulator;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  square_accumulator_if #(.W(W)) bus ();

  square_accumulator #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request. pulse=1 drops st right after the load edge; new_x>=0 is
  // presented on the operand bus after edge 1 and must be ignored.
  task automatic run_op(input int xv, input bit pulse, input int new_x, input int hold);
    int exp_sq;
    exp_sq = xv * xv;
    bus.x  = W'(xv);
    bus.st = 1'b1;
    tick();                                   // edge 0: load
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_done", 32'(bus.done), 32'd0);
    chk("load_sq",   32'(bus.sq),   32'd0);
    if (pulse) bus.st = 1'b0;
    for (int k = 1; k <= xv; k++) begin
      tick();                                 // edge k: k-th addition
      chk("partial_sq", 32'(bus.sq), 32'(k * k));
      chk("add_busy",   32'(bus.busy), 32'd1);
      chk("add_done",   32'(bus.done), 32'd0);
      if (k == 1 && new_x >= 0) bus.x = W'(new_x);
    end
    tick();                                   // edge x+1: enter DONE
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_sq",   32'(bus.sq),   32'(exp_sq));
    if (pulse) begin
      chk("pulse_done", 32'(bus.done), 32'd0);
      tick();                                 // back to IDLE
      chk("pulse_idle_done", 32'(bus.done), 32'd0);
      chk("pulse_idle_busy", 32'(bus.busy), 32'd0);
      chk("pulse_idle_sq",   32'(bus.sq),   32'(exp_sq));
    end else begin
      chk("done_latency", 32'(bus.done), 32'd1);
      for (int h = 0; h < hold; h++) begin
        tick();                               // st still held: no restart
        chk("hold_done", 32'(bus.done), 32'd1);
        chk("hold_busy", 32'(bus.busy), 32'd0);
        chk("hold_sq",   32'(bus.sq),   32'(exp_sq));
      end
      bus.st = 1'b0;
      #1;
      chk("release_done", 32'(bus.done), 32'd0);
      tick();                                 // DONE -> IDLE
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_sq",   32'(bus.sq),   32'(exp_sq));
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    bus.st = 1'b0;
    bus.x  = '0;
    tick();
    tick();
    chk("rst_sq",   32'(bus.sq),   32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tick();

    // Boundary operands, held handshake.
    run_op(0, 1'b0, -1, 1);
    run_op(15, 1'b0, -1, 2);

    // Operand change after load is ignored.
    run_op(9, 1'b0, 3, 0);

    // Single-cycle st pulse: completes silently.
    run_op(7, 1'b1, -1, 0);

    // Asynchronous reset in the middle of ADD.
    bus.x  = W'(12);
    bus.st = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) tick();
    chk("pre_abort_sq", 32'(bus.sq), 32'd25);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_sq",   32'(bus.sq),   32'd0);
    bus.st = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_abort_busy", 32'(bus.busy), 32'd0);
    run_op(5, 1'b0, -1, 0);

    // Sweep all operands back-to-back.
    for (int xv = 0; xv < 16; xv++) run_op(xv, 1'b0, -1, 0);

    // Randomized operands, hold lengths, pulses and ignored operand changes.
    for (int r = 0; r < 24; r++) begin
      int xv;
      int nx;
      xv = int'($urandom_range(0, 15));
      nx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      run_op(xv, ($urandom_range(0, 3) == 0), nx, int'($urandom_range(0, 3)));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
